mantissa_final_adder: RTL and testbench
=======================================

# mantissa_final_adder

Pipelined carry-propagate adder that closes the radix-8 MBE mantissa multiplier. It takes the two rows left by the last Dadda reduction stage and adds them in two 24-bit halves over two registered stages. It then emits the 48-bit product plus a normalized 24-bit mantissa with guard and sticky bits for the FP rounding logic downstream. Valid/ready handshaking at both ends allows full throughput and backpressure without data loss.

## Interface
- No parameters; widths are fixed at 48-bit rows / 24-bit mantissa.
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_row0/in_row1 hold a transaction
- in_ready  output  1  block accepts the transaction this cycle
- in_row0  input  48  sum row from final Dadda stage
- in_row1  input  48  carry row from final Dadda stage, already bit-aligned with in_row0
- out_valid  output  1  outputs hold a completed transaction
- out_ready  input  1  consumer accepts outputs this cycle
- product  output  48  (in_row0 + in_row1) mod 2^48
- mant  output  24  normalized mantissa
- norm  output  1  product[47]; consumer increments exponent when 1
- guard  output  1  first discarded bit below mant
- sticky  output  1  OR of all bits below guard

## Operation
- Stage A register (vA):
  - lo_sum = in_row0[23:0] + in_row1[23:0]; stores lo_sum[23:0] and carry cA = lo_sum[24].
  - Also stores in_row0[47:24] and in_row1[47:24] unchanged.
- Stage B register (vB):
  - hi = rowA0[47:24] + rowA1[47:24] + cA, truncated to 24 bits; a carry out of bit 47 is discarded.
  - product = {hi, loA}.
- Normalization is combinational from the stage B register:
  - norm=1: mant=product[47:24], guard=product[23], sticky=|product[22:0].
  - norm=0: mant=product[46:23], guard=product[22], sticky=|product[21:0].
- Handshake:
  - readyB = !vB | out_ready
  - readyA = !vA | readyB
  - in_ready = readyA
- Transfers:
  - Input transfer when in_valid & in_ready: stage A loads, vA set.
  - A→B transfer when vA & readyB: stage B loads, vB set.
  - vA clears when A empties into B with no new input; vB clears when out_valid & out_ready with no A→B transfer.
- Bubbles collapse: an empty stage B accepts from A regardless of out_ready.
- Transactions leave in acceptance order; none are dropped or duplicated.

## Timing
- Reset: vA=vB=0 and all data registers 0. Consequently out_valid=0, product=0, mant=0, norm=0, guard=0, sticky=0, in_ready=1 in the first cycle after reset.
- Latency: a transaction accepted at edge k presents out_valid=1 in the cycle after edge k+1, i.e. the earliest out_valid cycle is the second cycle after acceptance. This holds when stage B is free.
- Throughput: one transaction per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, all outputs hold stable.
  - Stage A fills once; in_ready then drops to 0 while both stages are full.
- Simultaneous events:
  - When the output is consumed, A moves to B, and a new input arrives all in one cycle, all three happen on that edge.
  - in_ready depends combinationally on out_ready; there is no other combinational input→output path.
- Reset mid-operation: rst=1 at any edge discards both stages. Outputs return to reset values on the next cycle regardless of handshake state.
- Inputs are sampled only on an accepting edge; in_row* may change freely otherwise.

## Test plan
- 1.0×1.0: row0=0x400000000000, row1=0 → product=0x400000000000, norm=0, mant=0x800000, guard=0, sticky=0; out_valid in the 2nd cycle after acceptance.
- Half-boundary carry: row0=0x000000FFFFFF, row1=0x000000000001 → product=0x000001000000, norm=0, mant=0x000002, guard=0, sticky=0.
- Max product: row0=0xFFFFFE000000, row1=0x000000000001 → product=0xFFFFFE000001, norm=1, mant=0xFFFFFE, guard=0, sticky=1.
- Backpressure: out_ready=0, offer T1..T3 back-to-back → T1, T2 accepted, in_ready=0 on T3. Outputs stay frozen on T1. After out_ready=1, T1, T2, T3 appear in order on consecutive cycles.
- Streaming: 100 random row pairs with in_valid=out_ready=1 → one result per cycle after a 2-cycle fill; every product equals (row0+row1) mod 2^48.
- Reset mid-stream: assert rst with both stages full → next cycle out_valid=0, in_ready=1, all outputs 0; no stale transaction appears afterwards.

Source files
------------

// File: rtl/mantissa_final_adder.sv
// Two-stage pipelined carry-propagate adder closing the MBE mantissa multiplier.
// Produces the 48-bit product plus a normalized 24-bit mantissa with guard/sticky.
module mantissa_final_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_row0,
  input  logic [47:0] in_row1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] product,
  output logic [23:0] mant,
  output logic        norm,
  output logic        guard,
  output logic        sticky
);

  logic        va;
  logic        vb;
  logic [23:0] lo_a;
  logic        carry_a;
  logic [23:0] row0_hi_a;
  logic [23:0] row1_hi_a;
  logic [47:0] product_b;

  logic        ready_b;
  logic        ready_a;
  logic        load_a;
  logic        move_ab;
  logic [24:0] lo_sum;
  logic [23:0] hi_sum;

  assign ready_b  = !vb || out_ready;
  assign ready_a  = !va || ready_b;
  assign in_ready = ready_a;
  assign load_a   = in_valid && ready_a;
  assign move_ab  = va && ready_b;

  assign lo_sum = {1'b0, in_row0[23:0]} + {1'b0, in_row1[23:0]};
  // Carry out of bit 47 is intentionally dropped: the product is mod 2^48.
  assign hi_sum = row0_hi_a + row1_hi_a + {23'd0, carry_a};

  // NOTE: all pipeline state uses non-blocking assignments so every register
  // samples pre-edge values and A->B and input->A can happen on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      va        <= 1'b0;
      vb        <= 1'b0;
      lo_a      <= '0;
      carry_a   <= 1'b0;
      row0_hi_a <= '0;
      row1_hi_a <= '0;
      product_b <= '0;
    end else begin
      if (load_a) begin
        va        <= 1'b1;
        lo_a      <= lo_sum[23:0];
        carry_a   <= lo_sum[24];
        row0_hi_a <= in_row0[47:24];
        row1_hi_a <= in_row1[47:24];
      end else if (move_ab) begin
        va <= 1'b0;
      end

      if (move_ab) begin
        vb        <= 1'b1;
        product_b <= {hi_sum, lo_a};
      end else if (out_ready) begin
        vb <= 1'b0;
      end
    end
  end

  assign out_valid = vb;
  assign product   = product_b;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave a latch behind.
  always_comb begin
    norm   = product_b[47];
    mant   = product_b[46:23];
    guard  = product_b[22];
    sticky = |product_b[21:0];
    if (norm) begin
      mant   = product_b[47:24];
      guard  = product_b[23];
      sticky = |product_b[22:0];
    end
  end

endmodule

// File: tb/tb_mantissa_final_adder.sv
// Directed self-checking bench for mantissa_final_adder: single transactions,
// backpressure, streaming and mid-stream reset.
module tb_mantissa_final_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_row0;
  logic [47:0] in_row1;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] product;
  logic [23:0] mant;
  logic        norm;
  logic        guard;
  logic        sticky;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mantissa_final_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row0   (in_row0),
    .in_row1   (in_row1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .mant      (mant),
    .norm      (norm),
    .guard     (guard),
    .sticky    (sticky)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_row0   = '0;
    in_row1   = '0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, product, mant, norm, guard, sticky} !== {1'b0, 1'b1, 48'd0, 24'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_state: got valid=%b ready=%b product=%h mant=%h n/g/s=%b%b%b, want 0 1 0 0 000",
               out_valid, in_ready, product, mant, norm, guard, sticky);
    end
  endtask

  // Offer one transaction with out_ready=1 and check latency and all fields.
  task automatic test_single(input string name, input logic [47:0] r0, input logic [47:0] r1,
                             input logic [47:0] exp_p, input logic [23:0] exp_m,
                             input logic exp_n, input logic exp_g, input logic exp_s);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_row0   = r0;
    in_row1   = r1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
    step();
    in_valid = 1'b0;
    in_row0  = 48'hDEAD_BEEF_CAFE;
    in_row1  = 48'h1234_5678_9ABC;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early_valid: got %b want 0", name, out_valid);
    end
    step();
    checks++;
    if ({out_valid, product, mant, norm, guard, sticky} !== {1'b1, exp_p, exp_m, exp_n, exp_g, exp_s}) begin
      errors++;
      $display("FAIL %s_result: got v=%b p=%h m=%h n/g/s=%b%b%b want v=1 p=%h m=%h n/g/s=%b%b%b",
               name, out_valid, product, mant, norm, guard, sticky, exp_p, exp_m, exp_n, exp_g, exp_s);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got valid=%b want 0", name, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] t_r0  [3];
    logic [47:0] t_r1  [3];
    logic [47:0] t_exp [3];
    t_r0[0] = 48'h0000_0000_0100; t_r1[0] = 48'h0000_0000_0023; t_exp[0] = 48'h0000_0000_0123;
    t_r0[1] = 48'hABC0_0000_0000; t_r1[1] = 48'h0000_00FF_F000; t_exp[1] = 48'hABC0_00FF_F000;
    t_r0[2] = 48'h7FFF_FF00_0000; t_r1[2] = 48'h0000_0100_0000; t_exp[2] = 48'h8000_0000_0000;

    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_row0  = t_r0[i];
      in_row1  = t_r1[i];
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_accept_t%0d: in_ready got %b want 1", i + 1, in_ready);
      end
      step();
    end
    in_row0 = t_r0[2];
    in_row1 = t_r1[2];
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({in_ready, out_valid, product} !== {1'b0, 1'b1, t_exp[0]}) begin
        errors++;
        $display("FAIL bp_stall_c%0d: got ready=%b valid=%b p=%h want 0 1 %h",
                 c, in_ready, out_valid, product, t_exp[0]);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, product} !== {1'b1, t_exp[i]}) begin
        errors++;
        $display("FAIL bp_order_t%0d: got valid=%b p=%h want 1 %h", i + 1, out_valid, product, t_exp[i]);
      end
      step();
      in_valid = 1'b0;
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [47:0] exp_q [100];
    logic [63:0] rnd;
    out_ready = 1'b1;
    for (int i = 0; i < 102; i++) begin
      if (i < 100) begin
        rnd      = {$urandom(), $urandom()};
        in_row0  = rnd[47:0];
        rnd      = {$urandom(), $urandom()};
        in_row1  = rnd[47:0];
        in_valid = 1'b1;
        exp_q[i] = in_row0 + in_row1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 100) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_ready_%0d: got %b want 1", i, in_ready);
        end
      end
      checks++;
      if (i >= 2) begin
        if ({out_valid, product} !== {1'b1, exp_q[i-2]}) begin
          errors++;
          $display("FAIL stream_result_%0d: got valid=%b p=%h want 1 %h", i - 2, out_valid, product, exp_q[i-2]);
        end
      end else if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stream_fill_%0d: got valid=%b want 0", i, out_valid);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_row0   = 48'hFFFF_FE00_0000;
    in_row1   = 48'h0000_0000_0001;
    step();
    in_row0 = 48'h4000_0000_0000;
    in_row1 = 48'h0000_0000_0000;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rst_mid_full: got valid=%b ready=%b want 1 0", out_valid, in_ready);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, product, mant, norm, guard, sticky} !== {1'b0, 1'b1, 48'd0, 24'd0, 3'b000}) begin
      errors++;
      $display("FAIL rst_mid_clear: got valid=%b ready=%b p=%h m=%h n/g/s=%b%b%b want 0 1 0 0 000",
               out_valid, in_ready, product, mant, norm, guard, sticky);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_stale_c%0d: got valid=%b p=%h want 0", c, out_valid, product);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single("one_x_one", 48'h4000_0000_0000, 48'h0000_0000_0000,
                48'h4000_0000_0000, 24'h800000, 1'b0, 1'b0, 1'b0);
    test_single("half_carry", 48'h0000_00FF_FFFF, 48'h0000_0000_0001,
                48'h0000_0100_0000, 24'h000002, 1'b0, 1'b0, 1'b0);
    test_single("max_product", 48'hFFFF_FE00_0000, 48'h0000_0000_0001,
                48'hFFFF_FE00_0001, 24'hFFFFFE, 1'b1, 1'b0, 1'b1);
    test_single("wrap_2_48", 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001,
                48'h0000_0000_0000, 24'h000000, 1'b0, 1'b0, 1'b0);
    test_single("guard_sticky", 48'h0000_0000_0000, 48'h4000_00C0_0001,
                48'h4000_00C0_0001, 24'h800001, 1'b0, 1'b1, 1'b1);
    test_backpressure();
    test_streaming();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
